seed_fn_in: RTL and testbench
=============================

# seed_fn_in

Input stage of the SEED encryption core and the counterpart of the ciphertext output stage. It accepts a 128-bit plaintext block over a valid/ready handshake and splits it into the 64-bit left and right halves for the round datapath. It then sequences the 4-bit `Rounds` counter through all 16 rounds on `clk_en` pulses. Finally it holds off the next block until the output stage has had time to capture the result.

## Interface
- `NUM_ROUNDS`, 16: rounds per block; legal range 1..16; last round index is `NUM_ROUNDS-1`.
- `DRAIN_EN_PULSES`, 2: `clk_en` pulses spent in DRAIN after the last round; must be ≥2 so the output stage sees `Rounds` leave `NUM_ROUNDS-1` and then capture.

- `clk`  in  1  internal 100MHz clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clk_en`  in  1  one-cycle pulse every 2 clock cycles; advances the round sequencer.
- `in_valid`  in  1  plaintext offered.
- `plaintext`  in  128  block; [127:64] is left, [63:0] is right.
- `in_ready`  out  1  block can be accepted this cycle.
- `L`  out  64  left half to round 0.
- `R`  out  64  right half to round 0.
- `load`  out  1  high for the full `clk_en` period in which round 0 takes `L`/`R`.
- `Rounds`  out  4  current round index.
- `busy`  out  1  a block is in flight.

## Operation
- Handshake: a transfer occurs on a rising `clk` edge with `in_valid && in_ready`. The handshake is not gated by `clk_en`. `plaintext` is captured into the block register on that edge.
- `in_ready` is a registered output: high in IDLE, low otherwise. With `SEED_FN_IN_SKID_EN` it is also high when the skid slot is empty.
- States are one-hot: IDLE, LOAD, RUN, DRAIN.
- IDLE, on accept: go to LOAD on the same edge. This transition does not wait for `clk_en`.
- LOAD, on `clk_en`:
  - `L` <= block[127:64], `R` <= block[63:0], `load` <= 1, `Rounds` <= 0.
  - Go to RUN.
- RUN, on `clk_en`:
  - `load` <= 0.
  - If `Rounds == NUM_ROUNDS-1`: `Rounds` <= 0, drain counter <= 0, go to DRAIN.
  - Otherwise `Rounds` <= `Rounds`+1.
- DRAIN, on `clk_en`: increment the drain counter. When it reaches `DRAIN_EN_PULSES-1`, go to IDLE. If a skid block is held, go to LOAD instead.
- `busy` = not IDLE, registered.
- `L`/`R` hold their value after `load` falls, until the next LOAD.
- `Rounds` is 4 bits. Wrap from 15 to 0 is explicit, never by overflow.
- `in_valid` while not ready is ignored. `plaintext` is sampled only on an accepted transfer.
- Reset mid-operation: all state is cleared immediately and asynchronously. The in-flight block and the skid block are discarded. No `load` is issued afterwards.

## Timing
- Reset values:
  - `in_ready` = 0, asserted on the first clock edge after `reset` deasserts.
  - `L` = 0, `R` = 0, `load` = 0, `Rounds` = 0, `busy` = 0.
  - State = IDLE.
- Accept to `load` high: 1 to 2 clock cycles, i.e. the next `clk_en` after the accept edge.
- `load` width: exactly one `clk_en` period (2 clocks).
- Round sequence: `Rounds` takes values 0..NUM_ROUNDS-1, each held for one `clk_en` period.
- Block occupancy: 1 LOAD pulse + NUM_ROUNDS + DRAIN_EN_PULSES `clk_en` pulses. Default is 19 pulses, 38 clocks.
- Back-to-back blocks: the next `load` follows the last DRAIN pulse by one `clk_en` when a skid block is held.
- `clk_en` asserted in the same cycle as accept: ignored for sequencing. LOAD waits for the following `clk_en`.

## Configuration
- `SEED_FN_IN_SKID_EN` defined:
  - A one-entry skid register accepts a new block while `busy`.
  - `in_ready` = skid empty.
  - On leaving DRAIN, the skid block moves to the block register and the FSM enters LOAD.
- Not defined:
  - No skid register.
  - `in_ready` = IDLE only.
  - A new block is accepted only after DRAIN completes.

## Test plan
- Reset, then offer plaintext 0x0123456789ABCDEF_FEDCBA9876543210 -> `load` high on the next `clk_en`:
  - `L`=0x0123456789ABCDEF, `R`=0xFEDCBA9876543210.
  - `Rounds` steps 0..15, then 0.
  - `busy` falls 18 `clk_en` pulses after `load`.
- `in_valid` held high while busy, no skid -> `in_ready`=0 throughout and no second capture. The second block is accepted on the first cycle back in IDLE.
- With `SEED_FN_IN_SKID_EN`, two blocks offered back-to-back -> both accepted. The second `load` occurs exactly 1 `clk_en` after the first block's DRAIN ends, with the second block's halves.
- Assert `reset` when `Rounds`=7 -> all outputs are 0 immediately with no clock. After release, the FSM is in IDLE with `in_ready`=1 and no stale `load`.
- Accept coinciding with a `clk_en` pulse -> `load` appears at the next `clk_en` (2 clocks later), not in the same cycle.
- `NUM_ROUNDS`=4 -> `Rounds` sequence is 0,1,2,3,0. DRAIN lasts exactly 2 `clk_en` pulses.

Source files
------------

// File: rtl/seed_fn_in.sv
// seed_fn_in: SEED plaintext input stage, block split and round sequencer.
// Define SEED_FN_IN_SKID_EN for a one-entry skid slot (back-to-back blocks).
module seed_fn_in #(
  parameter int NUM_ROUNDS      = 16,
  parameter int DRAIN_EN_PULSES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         in_valid,
  input  logic [127:0] plaintext,
  output logic         in_ready,
  output logic [63:0]  L,
  output logic [63:0]  R,
  output logic         load,
  output logic [3:0]   Rounds,
  output logic         busy
);

  localparam int DW =
    (DRAIN_EN_PULSES > 1) ? $clog2(DRAIN_EN_PULSES) : 1;
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);
  localparam logic [DW-1:0] LAST_DRN = DW'(DRAIN_EN_PULSES - 1);

  localparam int I_IDLE  = 0;
  localparam int I_LOAD  = 1;
  localparam int I_RUN   = 2;
  localparam int I_DRAIN = 3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_LOAD  = 4'b0010,
    S_RUN   = 4'b0100,
    S_DRAIN = 4'b1000
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  blk_q, blk_d;
  logic [63:0]   l_q, l_d;
  logic [63:0]   r_q, r_d;
  logic          load_q, load_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [DW-1:0] drn_q, drn_d;
  logic          busy_q, busy_d;
  logic          rdy_q, rdy_d;
  logic          accept;

`ifdef SEED_FN_IN_SKID_EN
  logic [127:0]  skid_q, skid_d;
  logic          skid_vld_q, skid_vld_d;
`endif

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    l_d     = l_q;
    r_d     = r_q;
    load_d  = load_q;
    rnd_d   = rnd_q;
    drn_d   = drn_q;
    accept  = in_valid && rdy_q;
`ifdef SEED_FN_IN_SKID_EN
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    // A block offered while one is in flight parks in the skid slot.
    if (accept && !state_q[I_IDLE]) begin
      skid_d     = plaintext;
      skid_vld_d = 1'b1;
    end
`endif
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (accept) begin
          blk_d   = plaintext;
          state_d = S_LOAD;
        end
      end
      state_q[I_LOAD]: begin
        if (clk_en) begin
          l_d     = blk_q[127:64];
          r_d     = blk_q[63:0];
          load_d  = 1'b1;
          rnd_d   = 4'd0;
          state_d = S_RUN;
        end
      end
      state_q[I_RUN]: begin
        if (clk_en) begin
          load_d = 1'b0;
          if (rnd_q == LAST_RND) begin
            rnd_d   = 4'd0;
            drn_d   = '0;
            state_d = S_DRAIN;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      state_q[I_DRAIN]: begin
        if (clk_en) begin
          drn_d = drn_q + DW'(1);
          if (drn_q == LAST_DRN) begin
            state_d = S_IDLE;
`ifdef SEED_FN_IN_SKID_EN
            // A block arriving on the exit edge bypasses the slot.
            if (skid_vld_q) begin
              blk_d      = skid_q;
              skid_vld_d = 1'b0;
              state_d    = S_LOAD;
            end else if (accept) begin
              blk_d      = plaintext;
              skid_vld_d = 1'b0;
              state_d    = S_LOAD;
            end
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SEED_FN_IN_SKID_EN
    rdy_d = !skid_vld_d;
`else
    rdy_d = (state_d == S_IDLE);
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      load_q  <= 1'b0;
      rnd_q   <= 4'd0;
      drn_q   <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      l_q     <= l_d;
      r_q     <= r_d;
      load_q  <= load_d;
      rnd_q   <= rnd_d;
      drn_q   <= drn_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef SEED_FN_IN_SKID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`endif

  assign in_ready = rdy_q;
  assign L        = l_q;
  assign R        = r_q;
  assign load     = load_q;
  assign Rounds   = rnd_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_seed_fn_in.sv
// tb_seed_fn_in: directed and randomized checks of seed_fn_in
// against a pulse-schedule reference model (16- and 4-round instances).
module tb_seed_fn_in;

  localparam int DR = 2;
`ifdef SEED_FN_IN_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clk_en = 1'b0;
  logic         iv_a = 1'b0, iv_b = 1'b0;
  logic [127:0] pt_a = '0, pt_b = '0;
  logic         rdy_a, rdy_b, load_a, load_b, busy_a, busy_b;
  logic [63:0]  L_a, R_a, L_b, R_b;
  logic [3:0]   rn_a, rn_b;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  bit ph = 1'b0;
  bit ce_s;
  bit dacc [2];

  int           NR [2] = '{16, 4};
  bit           m_act [2];
  int           m_k [2];
  bit           m_pv [2];
  bit           m_rdy [2];
  logic [127:0] m_blk [2];
  logic [127:0] m_pend [2];
  logic [63:0]  m_L [2];
  logic [63:0]  m_R [2];

  always #5 clk = ~clk;

  seed_fn_in #(.NUM_ROUNDS(16), .DRAIN_EN_PULSES(DR)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_valid(iv_a), .plaintext(pt_a), .in_ready(rdy_a),
    .L(L_a), .R(R_a), .load(load_a), .Rounds(rn_a), .busy(busy_a)
  );

  seed_fn_in #(.NUM_ROUNDS(4), .DRAIN_EN_PULSES(DR)) dut4 (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_valid(iv_b), .plaintext(pt_b), .in_ready(rdy_b),
    .L(L_b), .R(R_b), .load(load_b), .Rounds(rn_b), .busy(busy_b)
  );

  // Reference: a block is a timeline of clk_en pulses counted from
  // its accept; pulse 0 loads, 1..N-1 are rounds, N..N+DR finish it.
  task automatic mdl_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_k[d] = 0; m_pv[d] = 0; m_rdy[d] = 0;
      m_blk[d] = '0; m_pend[d] = '0; m_L[d] = '0; m_R[d] = '0;
    end
  endtask

  task automatic mdl_edge(input int d, input bit ce, input bit acc,
                          input logic [127:0] pt);
    bit took;
    int p;
    took = 0;
    if (m_act[d] && ce) m_k[d]++;
    p = m_k[d] - 1;
    if (m_act[d] && ce && p == 0) begin
      m_L[d] = m_blk[d][127:64];
      m_R[d] = m_blk[d][63:0];
    end
    if (m_act[d] && ce && p == NR[d] + DR) begin
      if (m_pv[d]) begin
        m_blk[d] = m_pend[d]; m_pv[d] = 0; m_k[d] = 0;
      end else if (acc) begin
        m_blk[d] = pt; m_k[d] = 0; took = 1;
      end else begin
        m_act[d] = 0;
      end
    end else if (!m_act[d] && acc) begin
      m_act[d] = 1; m_blk[d] = pt; m_k[d] = 0; took = 1;
    end
    if (acc && !took) begin
      m_pend[d] = pt; m_pv[d] = 1;
    end
    m_rdy[d] = SKID ? !m_pv[d] : !m_act[d];
  endtask

  function automatic logic [6:0] exp_ctl(input int d);
    int p;
    logic ld;
    logic [3:0] rn;
    p  = m_k[d] - 1;
    ld = m_act[d] && (p == 0);
    rn = (m_act[d] && p >= 1 && p < NR[d]) ? 4'(p) : 4'd0;
    return {ld, m_act[d], m_rdy[d], rn};
  endfunction

  task automatic step();
    bit aa, ab;
    @(negedge clk);
    clk_en = ph;
    ph = !ph;
    dacc[0] = iv_a && rdy_a;
    dacc[1] = iv_b && rdy_b;
    @(posedge clk);
    ce_s = clk_en;
    aa = iv_a && m_rdy[0];
    ab = iv_b && m_rdy[1];
    if (!reset) begin
      mdl_edge(0, ce_s, aa, pt_a);
      mdl_edge(1, ce_s, ab, pt_b);
    end
    cyc++;
    #1;
  endtask

  task automatic settle();
    repeat (90) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mdl_reset();
    repeat (3) step();
    tests++;
    if ({L_a, R_a, load_a, rn_a, busy_a, rdy_a} !== '0) begin
      failed++;
      $display("FAIL reset_a got=%h %h %b %h %b %b req=all 0",
               L_a, R_a, load_a, rn_a, busy_a, rdy_a);
    end
    tests++;
    if ({L_b, R_b, load_b, rn_b, busy_b, rdy_b} !== '0) begin
      failed++;
      $display("FAIL reset_b got=%h %h %b %h %b %b req=all 0",
               L_b, R_b, load_b, rn_b, busy_b, rdy_b);
    end
    reset = 1'b0;
    tests++;
    if (rdy_a !== 1'b0) begin
      failed++;
      $display("FAIL ready_pre_edge got=%b req=0", rdy_a);
    end
    step();
    tests++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      failed++;
      $display("FAIL ready_first_edge got=%b%b req=11", rdy_a, rdy_b);
    end
  endtask

  task automatic test_basic();
    logic [127:0] blk;
    logic [3:0] seq [20];
    int n, lat, pulses, lw;
    blk = 128'h0123456789ABCDEF_FEDCBA9876543210;
    iv_a = 1'b1; pt_a = blk; n = 0;
    do begin step(); n++; end while (!dacc[0] && n < 50);
    iv_a = 1'b0; pt_a = '0;
    tests++;
    if (!dacc[0]) begin
      failed++; $display("FAIL basic_accept got=0 req=1");
    end
    lat = 0;
    while (load_a !== 1'b1 && lat < 6) begin step(); lat++; end
    tests++;
    if (lat < 1 || lat > 2 || !ce_s) begin
      failed++;
      $display("FAIL basic_latency got=%0d ce=%b req=1..2 on clk_en",
               lat, ce_s);
    end
    tests++;
    if (L_a !== 64'h0123456789ABCDEF || R_a !== 64'hFEDCBA9876543210) begin
      failed++;
      $display("FAIL basic_halves got=%h_%h req=%h", L_a, R_a, blk);
    end
    seq[0] = rn_a; pulses = 0; lw = 1;
    for (int i = 0; i < 60 && busy_a === 1'b1; i++) begin
      step();
      if (load_a === 1'b1) lw++;
      if (ce_s) begin
        pulses++;
        if (pulses < 20) seq[pulses] = rn_a;
      end
    end
    tests++;
    if (lw != 2) begin
      failed++; $display("FAIL load_width got=%0d req=2", lw);
    end
    tests++;
    if (pulses != 18) begin
      failed++; $display("FAIL busy_fall got=%0d req=18", pulses);
    end
    for (int j = 0; j <= 18; j++) begin
      tests++;
      if (seq[j] !== 4'(j < 16 ? j : 0)) begin
        failed++;
        $display("FAIL round_seq[%0d] got=%0d req=%0d",
                 j, seq[j], (j < 16 ? j : 0));
      end
    end
    tests++;
    if (L_a !== blk[127:64] || R_a !== blk[63:0]) begin
      failed++; $display("FAIL halves_hold got=%h_%h req=%h", L_a, R_a, blk);
    end
  endtask

`ifndef SEED_FN_IN_SKID_EN
  task automatic test_busy_hold();
    logic [127:0] a, b;
    int n, hi, early;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    iv_a = 1'b1; pt_a = a; n = 0;
    do begin step(); n++; end while (!dacc[0] && n < 50);
    tests++;
    if (!dacc[0]) begin
      failed++; $display("FAIL hold_first_accept got=0 req=1");
    end
    pt_a = b; hi = 0; early = 0;
    for (int k = 0; k < 60 && busy_a === 1'b1; k++) begin
      step();
      if (busy_a === 1'b1 && rdy_a !== 1'b0) hi++;
      if (dacc[0]) early++;
    end
    tests++;
    if (hi != 0 || early != 0) begin
      failed++;
      $display("FAIL hold_ready ready_hi=%0d captures=%0d req=0,0",
               hi, early);
    end
    step();
    iv_a = 1'b0;
    tests++;
    if (!dacc[0]) begin
      failed++; $display("FAIL hold_accept_first_idle got=0 req=1");
    end
    n = 0;
    while (load_a !== 1'b1 && n < 6) begin step(); n++; end
    tests++;
    if (L_a !== b[127:64] || R_a !== b[63:0]) begin
      failed++; $display("FAIL hold_second got=%h_%h req=%h", L_a, R_a, b);
    end
    settle();
  endtask
`else
  task automatic test_skid_b2b();
    logic [127:0] a, b;
    int n, pulses, second, bz;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    iv_a = 1'b1; pt_a = a; n = 0;
    do begin step(); n++; end while (!dacc[0] && n < 50);
    pt_a = b; n = 0;
    do begin step(); n++; end while (!dacc[0] && n < 10);
    iv_a = 1'b0;
    tests++;
    if (!dacc[0] || n != 1) begin
      failed++; $display("FAIL skid_accept got=%b after %0d req=1 after 1",
                         dacc[0], n);
    end
    n = 0;
    while (load_a !== 1'b1 && n < 6) begin step(); n++; end
    tests++;
    if (L_a !== a[127:64] || R_a !== a[63:0]) begin
      failed++; $display("FAIL skid_first got=%h_%h req=%h", L_a, R_a, a);
    end
    pulses = 0; second = -1; bz = 0;
    for (int i = 0; i < 80 && second < 0; i++) begin
      step();
      if (busy_a !== 1'b1) bz++;
      if (ce_s) pulses++;
      if (ce_s && load_a === 1'b1) second = pulses;
    end
    tests++;
    if (second != 19 || bz != 0) begin
      failed++;
      $display("FAIL skid_second_load got=%0d idle=%0d req=19,0", second, bz);
    end
    tests++;
    if (L_a !== b[127:64] || R_a !== b[63:0]) begin
      failed++; $display("FAIL skid_second got=%h_%h req=%h", L_a, R_a, b);
    end
    settle();
  endtask
`endif

  task automatic test_accept_on_ce();
    logic [127:0] a;
    int n, lat;
    for (int want = 1; want >= 0; want--) begin
      n = 0;
      while ((rdy_a !== 1'b1 || int'(ph) != want) && n < 100) begin
        step(); n++;
      end
      a = {$urandom, $urandom, $urandom, $urandom};
      iv_a = 1'b1; pt_a = a;
      step();
      iv_a = 1'b0;
      tests++;
      if (!dacc[0]) begin
        failed++; $display("FAIL ce_accept[%0d] got=0 req=1", want);
      end
      lat = 0;
      while (load_a !== 1'b1 && lat < 6) begin step(); lat++; end
      tests++;
      if (lat != (want != 0 ? 2 : 1)) begin
        failed++;
        $display("FAIL ce_latency[%0d] got=%0d req=%0d",
                 want, lat, (want != 0 ? 2 : 1));
      end
      tests++;
      if (L_a !== a[127:64] || R_a !== a[63:0]) begin
        failed++; $display("FAIL ce_halves got=%h_%h req=%h", L_a, R_a, a);
      end
      settle();
    end
  endtask

  task automatic test_reset_mid();
    int n, lds;
    iv_a = 1'b1; pt_a = {$urandom, $urandom, $urandom, $urandom}; n = 0;
    do begin step(); n++; end while (!dacc[0] && n < 50);
    iv_a = 1'b0; n = 0;
    while (rn_a !== 4'd7 && n < 60) begin step(); n++; end
    tests++;
    if (rn_a !== 4'd7) begin
      failed++; $display("FAIL mid_reach7 got=%0d req=7", rn_a);
    end
    #2;
    reset = 1'b1;
    mdl_reset();
    #1;
    tests++;
    if ({L_a, R_a, load_a, rn_a, busy_a, rdy_a} !== '0) begin
      failed++;
      $display("FAIL mid_reset_async got=%h %h %b %h %b %b req=all 0",
               L_a, R_a, load_a, rn_a, busy_a, rdy_a);
    end
    repeat (2) step();
    reset = 1'b0;
    step();
    tests++;
    if (rdy_a !== 1'b1 || busy_a !== 1'b0) begin
      failed++;
      $display("FAIL mid_idle ready=%b busy=%b req=1,0", rdy_a, busy_a);
    end
    lds = 0;
    repeat (6) begin
      step();
      if (load_a !== 1'b0) lds++;
    end
    tests++;
    if (lds != 0) begin
      failed++; $display("FAIL mid_stale_load got=%0d req=0", lds);
    end
  endtask

  task automatic test_rounds4();
    logic [127:0] a;
    logic [3:0] seq [20];
    int n, pulses, t4;
    a = {$urandom, $urandom, $urandom, $urandom};
    iv_b = 1'b1; pt_b = a; n = 0;
    do begin step(); n++; end while (!dacc[1] && n < 50);
    iv_b = 1'b0;
    n = 0;
    while (load_b !== 1'b1 && n < 6) begin step(); n++; end
    tests++;
    if (load_b !== 1'b1 || L_b !== a[127:64] || R_b !== a[63:0]) begin
      failed++;
      $display("FAIL r4_load load=%b got=%h_%h req=%h", load_b, L_b, R_b, a);
    end
    seq[0] = rn_b; pulses = 0;
    for (int i = 0; i < 40 && busy_b === 1'b1; i++) begin
      step();
      if (ce_s) begin
        pulses++;
        if (pulses < 20) seq[pulses] = rn_b;
      end
    end
    tests++;
    if (pulses != 6) begin
      failed++; $display("FAIL r4_pulses got=%0d req=6", pulses);
    end
    for (int j = 0; j <= 4; j++) begin
      tests++;
      if (seq[j] !== 4'(j < 4 ? j : 0)) begin
        failed++;
        $display("FAIL r4_seq[%0d] got=%0d req=%0d", j, seq[j],
                 (j < 4 ? j : 0));
      end
    end
    t4 = -1;
    for (int j = pulses; j >= 1; j--) if (seq[j] == 4'd0) t4 = j;
    tests++;
    if (pulses - t4 != 2) begin
      failed++; $display("FAIL r4_drain got=%0d req=2", pulses - t4);
    end
  endtask

  task automatic test_random();
    logic [6:0] ea, eb;
    for (int c = 0; c < 800; c++) begin
      iv_a = ($urandom_range(0, c < 400 ? 2 : 30) == 0);
      iv_b = ($urandom_range(0, c < 400 ? 2 : 30) == 0);
      pt_a = {$urandom, $urandom, $urandom, $urandom};
      pt_b = {$urandom, $urandom, $urandom, $urandom};
      step();
      ea = exp_ctl(0);
      eb = exp_ctl(1);
      tests++;
      if ({load_a, busy_a, rdy_a, rn_a} !== ea) begin
        failed++;
        $display("FAIL rand_ctl_a cyc=%0d got=%b req=%b", cyc,
                 {load_a, busy_a, rdy_a, rn_a}, ea);
      end
      tests++;
      if ({L_a, R_a} !== {m_L[0], m_R[0]}) begin
        failed++;
        $display("FAIL rand_lr_a cyc=%0d got=%h_%h req=%h_%h", cyc,
                 L_a, R_a, m_L[0], m_R[0]);
      end
      tests++;
      if ({load_b, busy_b, rdy_b, rn_b} !== eb) begin
        failed++;
        $display("FAIL rand_ctl_b cyc=%0d got=%b req=%b", cyc,
                 {load_b, busy_b, rdy_b, rn_b}, eb);
      end
      tests++;
      if ({L_b, R_b} !== {m_L[1], m_R[1]}) begin
        failed++;
        $display("FAIL rand_lr_b cyc=%0d got=%h_%h req=%h_%h", cyc,
                 L_b, R_b, m_L[1], m_R[1]);
      end
    end
    iv_a = 1'b0;
    iv_b = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d req=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_reset();
    test_reset();
    test_basic();
`ifdef SEED_FN_IN_SKID_EN
    test_skid_b2b();
`else
    test_busy_hold();
`endif
    test_accept_on_ce();
    test_reset_mid();
    test_rounds4();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
